spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised SPI master, the successor to the fixed 40-bit, two-target SPI controller. Adds variable frame length per request and N chip-selects. Adds a programmable SCLK divider and CPOL/CPHA modes. It sits between the waveform/config FIFOs and the analog front-end chips, and returns full-duplex read data through a response handshake.

Parameters:
FRAME_W, 40, maximum frame length in bits; shift register width
NUM_CS, 2, number of chip-select outputs
DIV_W, 8, width of the clock divider field
LEN_W, $clog2(FRAME_W+1), width of the request length field
CS_W, $clog2(NUM_CS) (min 1), width of the chip-select index

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_cs  in  CS_W  target chip-select index
req_len  in  LEN_W  bits to transfer
req_data  in  FRAME_W  TX data, MSB-aligned; bit FRAME_W-1 is sent first
req_div  in  DIV_W  half-period H = req_div+1 clk cycles
req_cpol  in  1  idle SCLK level
req_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
rsp_valid  out  1  one-cycle pulse at frame end
rsp_data  out  FRAME_W  RX data, LSB-aligned, upper bits zero
rsp_err  out  1  valid with rsp_valid; index was out of range or length was clamped
busy  out  1  high whenever the state is not IDLE
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_b  out  NUM_CS  active-low chip selects

Behaviour:
- Reset values: req_ready=0 during rst, then 1; busy=0; rsp_valid=0; rsp_data=0; rsp_err=0; sclk=0; mosi=0; cs_b=all ones; state=IDLE.
- Acceptance: on req_valid && req_ready, all req_* fields are latched; nothing is sampled afterwards.
- Length clamp: len = req_len, except 0 or values > FRAME_W become FRAME_W, which sets the err flag.
- Chip-select range: req_cs >= NUM_CS sets the err flag and asserts no cs_b, but the frame still runs. This makes it usable as a dummy clock burst.
- State IDLE: cs_b all high. sclk is registered from the live req_cpol, so the idle level tracks it. Accept moves to SETUP.
- State SETUP, H cycles:
  - cs_b[cs] low and sclk = cpol.
  - If cpha=0, mosi = first bit from the first cycle.
- State SHIFT, 2*len*H cycles: sclk toggles every H cycles.
  - cpha=0: leading edge samples miso; trailing edge drives the next bit. No drive after the last bit.
  - cpha=1: leading edge drives the bit; trailing edge samples.
  - Sampled bits shift in at the LSB of the rx register.
- State HOLD, H cycles: sclk = cpol, cs_b still low.
- Frame completion (transition back to IDLE):
  - cs_b all high, rsp_valid=1 for one cycle.
  - rsp_data = rx register; rsp_err = latched err flag.
- Latency: rsp_valid asserts exactly (2*len+2)*H+1 cycles after the accept edge.
- Back-to-back: a request accepted in the rsp_valid cycle is legal. This gives a minimum cs_b high time of 1 clk cycle.
- Response side: no backpressure. rsp_data holds its value until the next rsp_valid.
- Divider: one counter. The tick fires when count==div, then the counter reloads to 0. An edge counter (width LEN_W+1) counts sclk edges.
- Reset mid-frame: on the next edge, cs_b goes all high, sclk=0, and the partial rx data is discarded. No rsp_valid is generated.
- mosi retains its last value outside SHIFT/SETUP.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD)
  - CPOL/CPHA mode constants
  - function computing LEN_W
- Sub-module spi_clk_gen (DIV_W): takes clk, rst, en, div and produces a one-cycle half-period tick. The FSM and shift registers stay in the top level.

Test Plan:
- Mode 0, len=8, div=0, cs=1, data=0xA5<<32, miso loopback = mosi:
  - sclk is 8 pulses of period 2.
  - cs_b=2'b01 for cycles 1..18.
  - rsp_valid at cycle 19, rsp_data=0xA5, err=0.
- Mode 3 (cpol=1, cpha=1), len=40, div=3, miso driven 0x12_3456_789A:
  - sclk idles high; each half-period is 4 cycles.
  - rsp_data=0x123456789A; rsp_valid 329 cycles after accept.
- req_len=0 and req_len=45 (FRAME_W=40): 40 bits transferred and rsp_err=1.
- req_cs=3 with NUM_CS=2: cs_b stays 2'b11, sclk still toggles 2*len times, rsp_err=1.
- Back-to-back with req_valid held high: second accept coincides with rsp_valid, and cs_b is high for exactly 1 cycle between frames.
- rst asserted at bit 5 of a 16-bit frame:
  - next cycle cs_b all high, sclk=0, busy=0.
  - no rsp_valid.
  - a subsequent frame completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, mode constants and width helpers for the SPI master
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam logic CPOL_LOW  = 1'b0;
  localparam logic CPHA_LEAD = 1'b0;

  function automatic int calc_len_w(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

  function automatic int calc_cs_w(input int num_cs);
    return (num_cs <= 1) ? 1 : $clog2(num_cs);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period tick generator; counter restarts whenever disabled
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = en && (count == div);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - SPI master with variable frame length, N chip-selects, divider and CPOL/CPHA
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int FRAME_W = 40,
  parameter int NUM_CS  = 2,
  parameter int DIV_W   = 8,
  parameter int LEN_W   = calc_len_w(FRAME_W),
  parameter int CS_W    = calc_cs_w(NUM_CS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CS_W-1:0]    req_cs,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [FRAME_W-1:0] req_data,
  input  logic [DIV_W-1:0]   req_div,
  input  logic               req_cpol,
  input  logic               req_cpha,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic [NUM_CS-1:0]  cs_b
);

  spi_state_t state, state_n;

  logic [CS_W-1:0]    cs_q;
  logic               cs_ok_q;
  logic [LEN_W-1:0]   len_q;
  logic [DIV_W-1:0]   div_q;
  logic               cpol_q, cpha_q, err_q;
  logic [FRAME_W-1:0] tx_q, rx_q;
  logic [LEN_W:0]     edge_q, edge_n;
  logic               mosi_q, sample_q, done_q;
  logic               tick, accept, last_edge, drive, sample;
  logic               len_bad, cs_ok;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .div  (div_q),
    .tick (tick)
  );

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign len_bad   = (req_len == '0) || (req_len > LEN_W'(FRAME_W));
  assign cs_ok     = ({1'b0, req_cs} < (CS_W+1)'(NUM_CS));

  // edge_n is the 1-based index of the sclk edge the current tick produces
  assign edge_n    = edge_q + (LEN_W+1)'(1);
  assign last_edge = (edge_n == {len_q, 1'b0});
  assign drive     = (cpha_q == CPHA_LEAD) ? (!edge_n[0] && !last_edge) : edge_n[0];
  assign sample    = (cpha_q == CPHA_LEAD) ? edge_n[0] : !edge_n[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   if (tick) state_n = SHIFT;
      SHIFT:   if (tick && last_edge) state_n = HOLD;
      HOLD:    if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pins are registered from the FSM-rate values, so every pin lags the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q      <= '0;
      cs_ok_q   <= 1'b0;
      len_q     <= '0;
      div_q     <= '0;
      cpol_q    <= CPOL_LOW;
      cpha_q    <= CPHA_LEAD;
      err_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      edge_q    <= '0;
      mosi_q    <= 1'b0;
      sample_q  <= 1'b0;
      done_q    <= 1'b0;
      cs_b      <= '1;
      sclk      <= CPOL_LOW;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      done_q   <= (state == HOLD) && tick;
      if (sample_q) begin
        rx_q <= {rx_q[FRAME_W-2:0], miso};
      end
      if (accept) begin
        cs_q    <= req_cs;
        cs_ok_q <= cs_ok;
        len_q   <= len_bad ? LEN_W'(FRAME_W) : req_len;
        div_q   <= req_div;
        cpol_q  <= req_cpol;
        cpha_q  <= req_cpha;
        err_q   <= len_bad || !cs_ok;
        edge_q  <= '0;
        rx_q    <= '0;
        if (req_cpha == CPHA_LEAD) begin
          mosi_q <= req_data[FRAME_W-1];
          tx_q   <= req_data << 1;
        end else begin
          tx_q   <= req_data;
        end
      end else if (state == SHIFT && tick) begin
        edge_q   <= edge_n;
        sample_q <= sample;
        if (drive) begin
          mosi_q <= tx_q[FRAME_W-1];
          tx_q   <= tx_q << 1;
        end
      end
      cs_b      <= (state != IDLE && cs_ok_q) ? ~(NUM_CS'(1) << cs_q) : '1;
      sclk      <= (state == IDLE) ? req_cpol : ((state == SHIFT) ? (cpol_q ^ edge_q[0]) : cpol_q);
      mosi      <= mosi_q;
      rsp_valid <= done_q;
      if (done_q) begin
        rsp_data <= rx_q;
        rsp_err  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - self-checking bench with a behavioural SPI slave/reference model
module tb_spi_master_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cs = '0;
  logic [5:0]  req_len = '0;
  logic [39:0] req_data = '0;
  logic [7:0]  req_div = '0;
  logic        req_cpol = 1'b0;
  logic        req_cpha = 1'b0;
  logic        rsp_valid;
  logic [39:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b0;
  logic [2:0]  cs_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  spi_master_multi #(.FRAME_W(40), .NUM_CS(3), .DIV_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cs    (req_cs),
    .req_len   (req_len),
    .req_data  (req_data),
    .req_div   (req_div),
    .req_cpol  (req_cpol),
    .req_cpha  (req_cpha),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_b      (cs_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One frame against a slave model: the slave shifts mw out MSB-first and captures mosi
  task automatic run_frame(input logic [1:0] cs, input logic [5:0] ln, input logic [39:0] data,
                           input logic [7:0] dv, input logic pol, input logic pha,
                           input logic [39:0] mw);
    int L, H, lat, exp_lat, edges, mi, cs_low, cs_wrong;
    logic [39:0] mask, got_mosi;
    logic [2:0]  exp_cs;
    logic        err_exp, last_sclk;
    L        = (ln == 0 || ln > 40) ? 40 : int'(ln);
    H        = int'(dv) + 1;
    err_exp  = (ln == 0) || (ln > 40) || (cs > 2);
    exp_cs   = (cs > 2) ? 3'b111 : ~(3'b001 << cs);
    mask     = {40{1'b1}} >> (40 - L);
    exp_lat  = (2 * L + 2) * H + 1;
    got_mosi = '0;
    edges    = 0;
    cs_low   = 0;
    cs_wrong = 0;
    lat      = -1;
    mi       = 0;
    req_cs = cs; req_len = ln; req_data = data; req_div = dv;
    req_cpol = pol; req_cpha = pha; req_valid = 1'b1;
    if (!pha) begin
      miso = mw[L-1];
      mi   = 1;
    end
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    chk("ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("idle_sclk", sclk, pol);
    last_sclk = sclk;
    for (int c = 1; c <= 400 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy", busy, 1);
      if (cs_b != 3'b111) begin
        cs_low++;
        if (cs_b != exp_cs) cs_wrong++;
      end
      if (sclk != last_sclk) begin
        edges++;
        last_sclk = sclk;
        if (((edges % 2) == 1) != pha) begin
          got_mosi = {got_mosi[38:0], mosi};
        end else if (mi < L) begin
          miso = mw[L-1-mi];
          mi++;
        end
      end
      if (rsp_valid) lat = c;
    end
    chk("latency", lat, exp_lat);
    chk("rx_data", rsp_data, mw & mask);
    chk("rsp_err", rsp_err, err_exp);
    chk("sclk_edges", edges, 2 * L);
    chk("cs_low_cycles", cs_low, (cs > 2) ? 0 : (2 * L + 2) * H);
    chk("cs_value", cs_wrong, 0);
    chk("mosi_bits", got_mosi & mask, data >> (40 - L));
    chk("end_sclk", sclk, pol);
    @(negedge clk);
    chk("pulse_width", rsp_valid, 0);
    chk("rsp_hold", rsp_data, mw & mask);
  endtask

  initial begin
    int t, acc1, acc2, rv1, rv2, high_run, gap, cnt;
    bit seen_low, drop;
    logic [63:0] r1, r2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rdy_in_rst", req_ready, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_sclk0", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_b", cs_b, 3'b111);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", req_ready, 1);

    // Mode 0, 8 bits, loopback-equivalent miso pattern
    run_frame(2'd1, 6'd8, 40'hA5 << 32, 8'd0, 1'b0, 1'b0, 40'hA5);

    // Back-to-back with req_valid held
    miso = 1'b1;
    req_cs = 0; req_len = 4; req_div = 0; req_cpol = 0; req_cpha = 0;
    req_data = 40'h5 << 36;
    req_valid = 1'b1;
    t = 0; acc1 = -1; acc2 = -1; rv1 = -1; rv2 = -1;
    high_run = 0; gap = -1; seen_low = 0; drop = 0;
    for (int i = 0; i < 60; i++) begin
      if (drop) req_valid = 1'b0;
      if (rsp_valid) begin
        if (rv1 < 0) begin
          rv1 = t;
          chk("b2b_rx1", rsp_data, 40'hF);
        end else if (rv2 < 0) begin
          rv2 = t;
          chk("b2b_rx2", rsp_data, 40'hF);
        end
      end
      if (cs_b != 3'b111) begin
        if (seen_low && high_run > 0 && gap < 0) gap = high_run;
        seen_low = 1;
        high_run = 0;
      end else if (seen_low) begin
        high_run++;
      end
      if (req_valid && req_ready) begin
        if (acc1 < 0) acc1 = t + 1;
        else if (acc2 < 0) begin
          acc2 = t + 1;
          drop = 1;
        end
      end
      @(posedge clk);
      t++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_coincide", acc2, rv1);
    chk("b2b_cs_gap", gap, 1);
    chk("b2b_lat1", rv1 - acc1, 11);
    chk("b2b_lat2", rv2 - acc2, 11);

    // Mode 3, full 40-bit frame, divider 3
    r1 = {$urandom, $urandom};
    run_frame(2'd0, 6'd40, r1[39:0], 8'd3, 1'b1, 1'b1, 40'h12_3456_789A);

    // Length clamp and out-of-range chip select
    r1 = {$urandom, $urandom};
    run_frame(2'd2, 6'd0, r1[39:0], 8'd0, 1'b0, 1'b1, r1[63:24]);
    r1 = {$urandom, $urandom};
    run_frame(2'd0, 6'd45, r1[39:0], 8'd1, 1'b1, 1'b0, r1[63:24]);
    r1 = {$urandom, $urandom};
    run_frame(2'd3, 6'd8, r1[39:0], 8'd0, 1'b0, 1'b0, r1[63:24]);

    // Reset in the middle of a 16-bit frame
    req_cs = 0; req_len = 16; req_div = 0; req_cpol = 0; req_cpha = 0;
    req_data = 40'hFFFF << 24;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cs_b", cs_b, 3'b111);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("mid_rst_no_rsp", cnt, 0);
    r1 = {$urandom, $urandom};
    run_frame(2'd0, 6'd16, r1[39:0], 8'd0, 1'b0, 1'b0, r1[63:24]);

    // Randomised frames
    for (int k = 0; k < 8; k++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      run_frame(2'($urandom_range(0, 3)), 6'($urandom_range(0, 47)), r1[39:0],
                8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), r2[39:0]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
